// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE      = 2'b00,
    FAULT_MISALIGN  = 2'b01,
    FAULT_RANGE     = 2'b10,
    FAULT_NOT_READY = 2'b11
  } fault_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port word store: one write port, one registered read port.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory that self-clears to NOP, accepts a streamed program,
// and serves fetches with one-cycle latency plus a fault code.
module imem_loader
  import imem_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  input  logic                       load_done,
  output logic [$clog2(DEPTH):0]     load_count,
  output logic                       mem_ready,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_instr,
  output logic [1:0]                 fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] clear_cnt_q, clear_cnt_d;
  logic [CW-1:0] load_count_q, load_count_d;
  logic          pending_q, pending_d;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  logic              fetch_valid_q;
  fault_e            fault_q, fault_now;
  logic              nop_sel_q;
  logic [ADDR_W-1:0] word_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clear_cnt_q  <= '0;
      load_count_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      load_count_q <= load_count_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_cnt_d  = clear_cnt_q;
    load_count_d = load_count_q;
    pending_d    = pending_q;
    ram_we       = 1'b0;
    ram_waddr    = '0;
    ram_wdata    = NOP_WORD;
    load_ready   = 1'b0;

    unique case (state_q)
      CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = clear_cnt_q[AW-1:0];
        clear_cnt_d = clear_cnt_q + CW'(1);
        if (start) begin
          pending_d = 1'b1;
        end
        // A start arriving on the final clear cycle still counts.
        if (clear_cnt_q == LAST_IDX) begin
          state_d      = (pending_q || start) ? LOAD : RUN;
          pending_d    = 1'b0;
          load_count_d = '0;
        end
      end

      LOAD: begin
        load_ready = (load_count_q < DEPTH_CNT);
        if (load_valid && load_ready) begin
          ram_we       = 1'b1;
          ram_waddr    = load_count_q[AW-1:0];
          ram_wdata    = load_data;
          load_count_d = load_count_q + CW'(1);
        end
        if (start) begin
          load_count_d = '0;
        end else if (load_done) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (start) begin
          state_d      = LOAD;
          load_count_d = '0;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  assign word_idx = fetch_addr >> 2;

  always_comb begin
    fault_now = FAULT_NONE;
    if (state_q != RUN) begin
      fault_now = FAULT_NOT_READY;
    end else if (fetch_addr[1:0] != 2'b00) begin
      fault_now = FAULT_MISALIGN;
    end else if (word_idx >= ADDR_W'(DEPTH)) begin
      fault_now = FAULT_RANGE;
    end
  end

  assign ram_re = fetch_req && (fault_now == FAULT_NONE);

  // fault_q and nop_sel_q only move on a request, so fetch_instr holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fault_q       <= FAULT_NONE;
      nop_sel_q     <= 1'b1;
    end else begin
      fetch_valid_q <= fetch_req;
      if (fetch_req) begin
        fault_q   <= fault_now;
        nop_sel_q <= (fault_now != FAULT_NONE);
      end
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (word_idx[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign load_count  = load_count_q;
  assign mem_ready   = (state_q == RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_instr = nop_sel_q ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader at DEPTH=16: clear, load, fetch, faults,
// overflow, mid-load reset and start-during-clear.
module tb_imem_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              load_done = 1'b0;
  logic [CW-1:0]     load_count;
  logic              mem_ready;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic [1:0]        fetch_fault;

  int checks_done = 0;
  int errors = 0;

  imem_loader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_count  (load_count),
    .mem_ready   (mem_ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single fetch: request for one cycle, response checked one cycle later.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_instr, input logic [1:0] exp_fault);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    check({tag, "_instr"}, fetch_instr, exp_instr);
    check({tag, "_fault"}, {30'd0, fetch_fault}, {30'd0, exp_fault});
  endtask

  task automatic load_word(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  logic [31:0] prog [3];
  int n;
  logic saw_run;

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;

    // Reset state
    tick();
    tick();
    check("rst_mem_ready",   {31'd0, mem_ready},   32'd0);
    check("rst_load_ready",  {31'd0, load_ready},  32'd0);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_instr", fetch_instr,          32'h0);
    check("rst_fetch_fault", {30'd0, fetch_fault}, 32'd0);
    check("rst_load_count",  {27'd0, load_count},  32'd0);
    rst = 1'b0;

    // Clear takes exactly DEPTH cycles
    n = 0;
    while (!mem_ready && n < 40) begin
      tick();
      n++;
    end
    check("clear_cycles", n, 32'd16);
    fetch("clr_fetch8", 32'd8, 32'h0, 2'b00);
    tick();
    check("idle_valid", {31'd0, fetch_valid}, 32'd0);

    // Load three words and read them back-to-back
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready_on", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("load_count3", {27'd0, load_count}, 32'd3);
    check("run_after_done", {31'd0, mem_ready}, 32'd1);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      tick();
      check($sformatf("b2b%0d_valid", i), {31'd0, fetch_valid}, 32'd1);
      check($sformatf("b2b%0d_instr", i), fetch_instr, prog[i]);
      check($sformatf("b2b%0d_fault", i), {30'd0, fetch_fault}, 32'd0);
    end
    fetch_req = 1'b0;

    // Fault codes
    fetch("misalign6", 32'd6, 32'h0, 2'b01);
    fetch("range64", 32'd64, 32'h0, 2'b10);
    fetch("range_hi", 32'h8000_0000, 32'h0, 2'b10);
    fetch("misalign_hi", 32'h8000_0002, 32'h0, 2'b01);

    // start in RUN: same-cycle fetch sees old contents
    start = 1'b1;
    fetch("start_fetch0", 32'd0, prog[0], 2'b00);
    start = 1'b0;
    check("reload_ready", {31'd0, load_ready}, 32'd1);
    check("reload_count0", {27'd0, load_count}, 32'd0);
    fetch("notready_load", 32'd4, 32'h0, 2'b11);

    // Overflow: 17 words offered with load_valid held
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_data = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 14) check("ovf_ready_15", {31'd0, load_ready}, 32'd1);
      if (i == 15) check("ovf_ready_16", {31'd0, load_ready}, 32'd0);
    end
    load_valid = 1'b0;
    check("ovf_count", {27'd0, load_count}, 32'd16);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("ovf_count_run", {27'd0, load_count}, 32'd16);
    fetch("ovf_fetch60", 32'd60, 32'hA000_000F, 2'b00);
    fetch("ovf_fetch0", 32'd0, 32'hA000_0000, 2'b00);
    fetch("ovf_fetch12", 32'd12, 32'hA000_0003, 2'b00);

    // Reset mid-load drops in-flight fetch and wipes memory
    start = 1'b1;
    tick();
    start = 1'b0;
    load_word(32'h1111_1111);
    load_word(32'h2222_2222);
    rst = 1'b1;
    fetch_req = 1'b1;
    fetch_addr = 32'd0;
    tick();
    rst = 1'b0;
    fetch_req = 1'b0;
    check("rst_drop_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_drop_count", {27'd0, load_count}, 32'd0);
    fetch("clr_notready", 32'd0, 32'h0, 2'b11);
    n = 0;
    while (!mem_ready && n < 40) begin
      tick();
      n++;
    end
    check("reclear_ready", {31'd0, mem_ready}, 32'd1);
    fetch("wiped0", 32'd0, 32'h0, 2'b00);
    fetch("wiped60", 32'd60, 32'h0, 2'b00);

    // start during CLEAR goes straight to LOAD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    saw_run = 1'b0;
    tick(); n++;
    tick(); n++;
    start = 1'b1;
    tick(); n++;
    start = 1'b0;
    while (!load_ready && n < 40) begin
      if (mem_ready) saw_run = 1'b1;
      tick();
      n++;
    end
    if (mem_ready) saw_run = 1'b1;
    check("pend_cycles", n, 32'd16);
    check("pend_ready", {31'd0, load_ready}, 32'd1);
    check("pend_no_run", {31'd0, saw_run}, 32'd0);
    load_word(32'hCAFE_0001);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch("pend_fetch0", 32'd0, 32'hCAFE_0001, 2'b00);
    fetch("pend_fetch4", 32'd4, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks_done);
    $finish;
  end

endmodule
